// File: rtl/osc_pkg.sv
// Shared definitions for the MCU parallel-bus blocks of the oscilloscope FPGA.
package osc_pkg;

    localparam int MCU_DATA_W     = 8;
    localparam int SMP_FIFO_DEPTH = 16;

    typedef logic [MCU_DATA_W-1:0] mcu_byte_t;

endpackage

// File: rtl/mcu_oe_sync.sv
// Brings an asynchronous MCU strobe into the clk domain and emits a one-cycle
// pulse on its synchronized rising edge (end of the bus cycle).
module mcu_oe_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    // Idle-high reset: a strobe already low when reset releases never reads as a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/mcu_read_port.sv
// First-word-fall-through sample FIFO read out by the MCU one byte per oe strobe;
// the head byte is held in a register so it is stable before oe falls.
module mcu_read_port
    import osc_pkg::*;
#(
    parameter int DATA_W    = MCU_DATA_W,
    parameter int DEPTH     = SMP_FIFO_DEPTH,
    parameter int RDY_LEVEL = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    smp_valid,
    input  logic [DATA_W-1:0]       smp_data,
    input  logic                    oe,
    output logic [DATA_W-1:0]       mcu_dout,
    output logic                    mcu_dout_en,
    output logic                    data_rdy,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_rdy;
    logic              r_ovf;
    logic              r_udf;

    logic              w_pop;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_full;
    logic [CW-1:0]     w_cnt_after_pop;
    logic [CW-1:0]     w_cnt_nxt;
    logic [AW-1:0]     w_rptr_nxt;
    logic [DATA_W-1:0] w_head_nxt;

    mcu_oe_sync u_oe_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (oe),
        .o_rise  (w_pop)
    );

    always_comb begin
        w_full          = (r_count == CW'(DEPTH));
        w_pop_ok        = w_pop && (r_count != '0);
        w_push_ok       = smp_valid && (!w_full || w_pop);
        w_cnt_after_pop = r_count - CW'(w_pop_ok);
        w_cnt_nxt       = w_cnt_after_pop + CW'(w_push_ok);
        w_rptr_nxt      = r_rptr + AW'(w_pop_ok);
        w_head_nxt      = '0;
        // A sample pushed into a FIFO that is empty after this pop becomes the head directly.
        if (w_cnt_after_pop != '0) begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end else if (w_push_ok) begin
            w_head_nxt = smp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !clear) begin
            r_mem[r_wptr] <= smp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_rdy   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_rdy   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push_ok);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_cnt_nxt;
            r_dout  <= w_head_nxt;
            r_rdy   <= (w_cnt_nxt >= CW'(RDY_LEVEL));
            if (smp_valid && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_pop && (r_count == '0)) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign mcu_dout    = r_dout;
    assign mcu_dout_en = ~oe;
    assign data_rdy    = r_rdy;
    assign count       = r_count;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

endmodule

// File: tb/tb_mcu_read_port.sv
// Directed bench for mcu_read_port: push/strobe sequences with hand-computed results.
module tb_mcu_read_port;
    import osc_pkg::*;

    logic      clk;
    logic      rst;
    logic      clear;
    logic      smp_valid;
    mcu_byte_t smp_data;
    logic      oe;
    mcu_byte_t mcu_dout;
    logic      mcu_dout_en;
    logic      data_rdy;
    logic [4:0] count;
    logic      overflow;
    logic      underflow;

    int n_cmp;
    int n_err;

    mcu_read_port #(
        .DATA_W    (8),
        .DEPTH     (16),
        .RDY_LEVEL (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .oe          (oe),
        .mcu_dout    (mcu_dout),
        .mcu_dout_en (mcu_dout_en),
        .data_rdy    (data_rdy),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling clk edge.
    task automatic push(input logic [7:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic mcu_read(output logic [7:0] v);
        oe = 1'b0;
        @(negedge clk);
        v = mcu_dout;
        repeat (3) @(negedge clk);
        oe = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        clear     = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
        oe        = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_dout", 32'(mcu_dout), 0);
        check("rst_rdy", 32'(data_rdy), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_en_oe_hi", 32'(mcu_dout_en), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic three-byte transfer
        push(8'h11);
        check("t1_fwft_dout", 32'(mcu_dout), 32'h11);
        check("t1_count1", 32'(count), 1);
        push(8'h22);
        push(8'h33);
        check("t1_count3", 32'(count), 3);
        mcu_read(v); check("t1_rd0", 32'(v), 32'h11);
        mcu_read(v); check("t1_rd1", 32'(v), 32'h22);
        mcu_read(v); check("t1_rd2", 32'(v), 32'h33);
        check("t1_count_end", 32'(count), 0);
        check("t1_dout_end", 32'(mcu_dout), 0);
        check("t1_udf", 32'(underflow), 0);

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) push(8'(i));
        check("t2_count", 32'(count), 16);
        check("t2_ovf", 32'(overflow), 1);
        check("t2_rdy", 32'(data_rdy), 1);
        for (int i = 0; i < 16; i++) begin
            mcu_read(v);
            check("t2_rd", 32'(v), 32'(i));
        end
        check("t2_count_end", 32'(count), 0);
        check("t2_ovf_sticky", 32'(overflow), 1);
        do_clear();
        check("t2_ovf_clr", 32'(overflow), 0);

        // Push in the same cycle as a pop while full
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        oe = 1'b0;
        @(negedge clk);
        v = mcu_dout;
        repeat (3) @(negedge clk);
        oe = 1'b1;
        repeat (3) @(negedge clk);
        smp_valid = 1'b1;
        smp_data  = 8'hAA;
        @(negedge clk);
        smp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_rd_first", 32'(v), 32'h40);
        check("t3_count", 32'(count), 16);
        check("t3_ovf", 32'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            mcu_read(v);
            check("t3_rd", 32'(v), 32'(8'h40 + i));
        end
        mcu_read(v);
        check("t3_rd_last", 32'(v), 32'hAA);
        check("t3_count_end", 32'(count), 0);

        // Underflow
        mcu_read(v);
        check("t4_rd_empty", 32'(v), 0);
        check("t4_udf", 32'(underflow), 1);
        check("t4_count", 32'(count), 0);
        check("t4_dout", 32'(mcu_dout), 0);
        do_clear();
        check("t4_udf_clr", 32'(underflow), 0);

        // data_rdy threshold
        for (int i = 0; i < 7; i++) push(8'(8'h50 + i));
        check("t5_rdy7", 32'(data_rdy), 0);
        push(8'h57);
        check("t5_rdy8", 32'(data_rdy), 1);
        check("t5_count8", 32'(count), 8);
        mcu_read(v);
        check("t5_rd", 32'(v), 32'h50);
        check("t5_rdy_after", 32'(data_rdy), 0);
        check("t5_count7", 32'(count), 7);

        // Reset during a read
        do_clear();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        check("t6_count5", 32'(count), 5);
        oe = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_en_low", 32'(mcu_dout_en), 1);
        rst = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_dout", 32'(mcu_dout), 0);
        check("t6_en_in_rst", 32'(mcu_dout_en), 1);
        @(negedge clk);
        oe = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_udf", 32'(underflow), 0);
        check("t6_count_end", 32'(count), 0);
        check("t6_dout_end", 32'(mcu_dout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
